// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and
// the default bit period (50 MHz clock, 115200 baud).
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer for the UART transmitter.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   clear   : hold the counter at 0 (asserted while the transmitter idles)
//   tick    : high in the last clock of each bit period
// The counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned      CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST) && !clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, line idles high.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset; aborts any frame in progress
//   tx_start : request to send tx_data, honoured only while idle
//   tx_data  : byte to send, captured on the accepting edge
//   tx       : registered serial output
//   tx_busy  : high while a frame is in progress
//   tx_done  : one-cycle pulse in the first idle cycle after the stop bit
// A request present in the tx_done cycle is accepted at once, so frames can
// run back to back without an idle bit-time.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;
  logic                 tick;
  logic                 clear;

  // Holding the timer in reset while idle makes every bit period start
  // cleanly from 0 on the accepting edge.
  assign clear = (state == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_start) begin
            state   <= START;
            shreg   <= tx_data;
            bit_idx <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[DATA_BITS-1:1]};
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
            end
          end
        end
        STOP: begin
          if (tick) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
